dequantser: RTL and testbench
=============================

# dequantser

Bit-serial to parallel deserializer with programmable precision: the receiving end of the quantizer/serializer. It consumes one bit per `step` strobe, MSB first, and assembles `msbidx+1` bits into a parallel word. The word is presented on a valid/ready output port. It sits downstream of a bit-serial link or MVU output lane, where bit-serial results are regathered into words before writeback.

## Interface
- `BWOUT`, 32, output word width in bits.
- `BWMSBIDX`, `$clog2(BWOUT)`, width of the `msbidx` port.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `clr` input 1: synchronous clear of all state; same effect as `rst`, applied at the clock edge.
- `msbidx` input `BWMSBIDX`: bit position of the word MSB, so the precision is `msbidx+1` bits.
- `step` input 1: a serial bit is present on `din` this cycle.
- `din` input 1: serial data, MSB first.
- `dout` output `BWOUT`: assembled word; reset value 0.
- `dout_valid` output 1: `dout` holds an unaccepted word; reset value 0.
- `dout_ready` input 1: consumer accepts `dout` this cycle.
- `busy` output 1: a word is partially assembled (bit count ≠ 0); reset value 0.
- `ovf` output 1: sticky flag, set when a completed word was dropped; reset value 0.

## Operation
- **Internal state:**
  - shift register `sr[BWOUT-1:0]`
  - bit counter `cnt` (`BWMSBIDX` bits)
  - latched precision `msb_l`
  - output register `dout` / `dout_valid`
- **On `step`:**
  - `sr <= {sr[BWOUT-2:0], din}`.
  - If `cnt == 0`, `msbidx` is latched into `msb_l`. `msb_l` is used for the whole word, so `msbidx` changes mid-word have no effect until the next word.
- **Completion:** completion is the cycle with `step && cnt == msb_l`. The `cnt == 0` case uses `msbidx` directly, so precision 1 completes on every `step`. On completion:
  - `cnt` returns to 0.
  - The completed word is `{sr[BWOUT-2:0], din}`, masked to its low `msb_l+1` bits and extended to `BWOUT` (see Configuration).
- **Otherwise on `step`:** `cnt <= cnt + 1`.
- **Output register handshake:**
  - Acceptance occurs when `dout_valid && dout_ready`; it clears `dout_valid` next cycle unless a new word loads.
  - On completion, the new word loads if `!dout_valid` or acceptance occurs in the same cycle. This gives back-to-back throughput with no bubble.
  - On completion while `dout_valid && !dout_ready`, the new word is dropped, `dout` is held unchanged, and `ovf` is set.
  - `dout` is stable while `dout_valid=1 && dout_ready=0`.
- **`ovf`:** cleared only by `rst` or `clr`.
- **`clr` priority:** `clr` overrides `step` and `dout_ready` in the same cycle. An in-flight partial word is discarded. `rst` behaves identically, but asynchronously.
- **`busy`:** equals `cnt != 0`.

## Timing
- **Latency:** last bit sampled at edge N; `dout_valid=1` with the word after edge N, visible in cycle N+1.
- **Throughput:** one word per `msbidx+1` steps; steps need not be contiguous, and idle cycles hold all state.
- **Precision 1:** a word every step; sustainable only while `dout_ready` is held high.
- **Reset:** `rst` deasserting mid-word leaves `cnt=0`, `sr=0`, `dout=0`, `dout_valid=0`, `ovf=0`.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.

## Configuration
- `DEQUANTSER_SIGNEXT_EN` defined: the completed word is sign-extended from bit `msb_l` to `BWOUT`. Example: precision 4 with bits 1011 gives `dout = 0xFFFFFFFB`.
- Not defined: zero-extension, so the same input gives `dout = 0x0000000B`.
- With either setting, bits above `msb_l` never carry stale `sr` content.

## Structure
- Shared package `quant_pkg`:
  - default `BWOUT`
  - `BWMSBIDX` derivation function
  - extension-mode localparam
  - These are shared with the serializer so both ends agree on width and ordering.
- One natural sub-module: `dequantser_outreg`, the valid/ready output holding register with drop/overflow detection. The shift register, counter and precision latch stay in the top.

## Test plan
- **Precision 8, continuous ready:** `msbidx=7`, serial 1,0,1,0,0,1,0,1 on 8 consecutive steps → one cycle after the 8th step, `dout=0x000000A5` and `dout_valid=1` for 1 cycle; `busy` is high after step 1 and low after step 8.
- **Sign extension:** `msbidx=3`, bits 1,0,1,1 → `dout=0xFFFFFFFB` with `DEQUANTSER_SIGNEXT_EN` defined, `0x0000000B` without.
- **Backpressure and overflow:** `msbidx=1`, `dout_ready=0`, bits 1,1 then 0,1 → `dout` stays `0x3`, `ovf=1` after the 4th step; raising `dout_ready` then clears `dout_valid`, and `ovf` stays 1.
- **Simultaneous completion and acceptance:** `msbidx=0`, `dout_ready=1`, steps on consecutive cycles with bits 1,0,1 → `dout` is 1,0,1 on consecutive cycles, `dout_valid` is held high, and `ovf` stays 0.
- **Precision change mid-word:** `msbidx=3` at the first step, then changed to 1 after 2 steps → the word still completes after 4 steps, and the next word uses precision 2.
- **Clear mid-word:** `clr` pulsed after 3 of 8 bits, then 8 bits of 0xFF → `dout=0x000000FF`, with no residue from the discarded bits.
- **Async reset:** `rst` asserted between clock edges → all outputs read 0 immediately, before the next edge.

Source files
------------

// File: rtl/quant_pkg.sv
// Shared quantizer/serializer definitions: word width, counter-width derivation, extension mode.
// Extension mode is selected by DEQUANTSER_SIGNEXT_EN (defined: sign-extend, undefined: zero-extend).
package quant_pkg;

  localparam int BWOUT_DEFAULT = 32;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_mode_e;

`ifdef DEQUANTSER_SIGNEXT_EN
  localparam ext_mode_e EXT_MODE = EXT_SIGN;
`else
  localparam ext_mode_e EXT_MODE = EXT_ZERO;
`endif

  // A 1-bit word still needs a 1-bit msbidx port.
  function automatic int bwmsbidx(input int bw);
    return (bw > 1) ? $clog2(bw) : 1;
  endfunction

endpackage

// File: rtl/dequantser_outreg.sv
// Valid/ready output holding register; a word completing while the held one is unaccepted is dropped and flagged.
module dequantser_outreg #(
  parameter int BWOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [BWOUT-1:0] load_data,
  input  logic             dout_ready,
  output logic [BWOUT-1:0] dout,
  output logic             dout_valid,
  output logic             ovf
);

  logic accept;
  logic room;

  assign accept = dout_valid && dout_ready;
  assign room   = !dout_valid || dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
    end else if (clr) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
    end else if (load && room) begin
      dout       <= load_data;
      dout_valid <= 1'b1;
    end else if (load) begin
      ovf <= 1'b1;
    end else if (accept) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dequantser.sv
// Bit-serial (MSB first) to parallel deserializer with per-word precision msbidx+1.
// Completed words are sign-extended when DEQUANTSER_SIGNEXT_EN is defined, else zero-extended.
module dequantser
  import quant_pkg::*;
#(
  parameter int BWOUT    = BWOUT_DEFAULT,
  parameter int BWMSBIDX = bwmsbidx(BWOUT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [BWMSBIDX-1:0] msbidx,
  input  logic                step,
  input  logic                din,
  output logic [BWOUT-1:0]    dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                busy,
  output logic                ovf
);

  logic [BWOUT-1:0]    sr_reg;
  logic [BWMSBIDX-1:0] cnt_reg;
  logic [BWMSBIDX-1:0] msb_l_reg;
  logic [BWMSBIDX-1:0] msb_eff;
  logic [BWOUT-1:0]    word_raw;
  logic [BWOUT-1:0]    word_ext;
  logic                complete;
  logic                sign_bit;

  // The first bit of a word has not latched msbidx yet, so it is used directly.
  assign msb_eff  = (cnt_reg == '0) ? msbidx : msb_l_reg;
  assign word_raw = {sr_reg[BWOUT-2:0], din};
  assign complete = step && (cnt_reg == msb_eff);
  assign sign_bit = (EXT_MODE == EXT_SIGN) && word_raw[msb_eff];
  assign busy     = (cnt_reg != '0);

  // Bits above the word MSB are replaced, so stale shift-register content never leaks out.
  for (genvar gi = 0; gi < BWOUT; gi++) begin : g_ext
    assign word_ext[gi] = (BWMSBIDX'(gi) <= msb_eff) ? word_raw[gi] : sign_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg    <= '0;
      cnt_reg   <= '0;
      msb_l_reg <= '0;
    end else if (clr) begin
      sr_reg    <= '0;
      cnt_reg   <= '0;
      msb_l_reg <= '0;
    end else if (step) begin
      sr_reg <= word_raw;
      if (cnt_reg == '0) begin
        msb_l_reg <= msbidx;
      end
      cnt_reg <= complete ? '0 : cnt_reg + 1'b1;
    end
  end

  dequantser_outreg #(
    .BWOUT(BWOUT)
  ) u_outreg (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .load       (complete),
    .load_data  (word_ext),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ovf        (ovf)
  );

endmodule

// File: tb/tb_dequantser.sv
// Directed scoreboard bench for dequantser: expected words are queued at stimulus time and
// compared by an independent monitor on every accepted output.
module tb_dequantser;

  localparam int BW  = 32;
  localparam int BWM = 5;

`ifdef DEQUANTSER_SIGNEXT_EN
  localparam logic [31:0] EXP_A5  = 32'hFFFFFFA5;
  localparam logic [31:0] EXP_B   = 32'hFFFFFFFB;
  localparam logic [31:0] EXP_3   = 32'hFFFFFFFF;
  localparam logic [31:0] EXP_ONE = 32'hFFFFFFFF;
  localparam logic [31:0] EXP_2   = 32'hFFFFFFFE;
  localparam logic [31:0] EXP_FF  = 32'hFFFFFFFF;
`else
  localparam logic [31:0] EXP_A5  = 32'h000000A5;
  localparam logic [31:0] EXP_B   = 32'h0000000B;
  localparam logic [31:0] EXP_3   = 32'h00000003;
  localparam logic [31:0] EXP_ONE = 32'h00000001;
  localparam logic [31:0] EXP_2   = 32'h00000002;
  localparam logic [31:0] EXP_FF  = 32'h000000FF;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clr = 1'b0;
  logic [BWM-1:0] msbidx = '0;
  logic           step = 1'b0;
  logic           din = 1'b0;
  logic [BW-1:0]  dout;
  logic           dout_valid;
  logic           dout_ready = 1'b0;
  logic           busy;
  logic           ovf;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  dequantser #(.BWOUT(BW), .BWMSBIDX(BWM)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .msbidx     (msbidx),
    .step       (step),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .ovf        (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // One serial bit, sampled at the next rising edge; back-to-back calls give contiguous steps.
  task automatic step1(input logic b);
    step = 1'b1;
    din  = b;
    @(posedge clk);
    #1;
    step = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  // Monitor: every handshake the DUT presents must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%08h expected none", dout);
      end else begin
        check("word", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1;
    check("reset_dout", dout, 32'h0);
    check("reset_valid", {31'b0, dout_valid}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_ovf", {31'b0, ovf}, 32'h0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Precision 8, continuous ready: 1010_0101
    dout_ready = 1'b1;
    msbidx = 5'd7;
    exp_q.push_back(EXP_A5);
    step1(1'b1);
    check("busy_after_first", {31'b0, busy}, 32'h1);
    step1(1'b0); step1(1'b1); step1(1'b0);
    step1(1'b0); step1(1'b1); step1(1'b0); step1(1'b1);
    check("busy_after_last", {31'b0, busy}, 32'h0);
    check("valid_after_last", {31'b0, dout_valid}, 32'h1);
    idle(1);
    check("valid_one_cycle", {31'b0, dout_valid}, 32'h0);

    // Extension mode: precision 4, bits 1011
    msbidx = 5'd3;
    exp_q.push_back(EXP_B);
    step1(1'b1); step1(1'b0); step1(1'b1); step1(1'b1);
    idle(2);

    // Backpressure: second word must be dropped and flagged
    dout_ready = 1'b0;
    msbidx = 5'd1;
    check("ovf_before", {31'b0, ovf}, 32'h0);
    exp_q.push_back(EXP_3);
    step1(1'b1); step1(1'b1);
    step1(1'b0); step1(1'b1);
    check("held_dout", dout, EXP_3);
    check("ovf_set", {31'b0, ovf}, 32'h1);
    idle(1);
    dout_ready = 1'b1;
    idle(1);
    check("valid_cleared", {31'b0, dout_valid}, 32'h0);
    check("ovf_sticky", {31'b0, ovf}, 32'h1);

    pulse_clr();
    check("ovf_cleared", {31'b0, ovf}, 32'h0);

    // Precision 1 with simultaneous completion and acceptance
    msbidx = 5'd0;
    exp_q.push_back(EXP_ONE);
    exp_q.push_back(32'h0);
    exp_q.push_back(EXP_ONE);
    step1(1'b1);
    check("p1_valid_1", {31'b0, dout_valid}, 32'h1);
    step1(1'b0);
    check("p1_valid_2", {31'b0, dout_valid}, 32'h1);
    step1(1'b1);
    check("p1_valid_3", {31'b0, dout_valid}, 32'h1);
    idle(1);
    check("p1_ovf", {31'b0, ovf}, 32'h0);

    // Precision change mid-word takes effect only on the next word
    msbidx = 5'd3;
    exp_q.push_back(EXP_B);
    step1(1'b1); step1(1'b0);
    msbidx = 5'd1;
    step1(1'b1);
    check("midword_busy", {31'b0, busy}, 32'h1);
    step1(1'b1);
    check("midword_done", {31'b0, busy}, 32'h0);
    exp_q.push_back(EXP_2);
    step1(1'b1); step1(1'b0);
    check("next_prec2_done", {31'b0, busy}, 32'h0);
    idle(2);

    // Clear discards a partial word
    msbidx = 5'd7;
    step1(1'b1); step1(1'b0); step1(1'b1);
    pulse_clr();
    check("clr_busy", {31'b0, busy}, 32'h0);
    exp_q.push_back(EXP_FF);
    repeat (8) step1(1'b1);
    idle(2);

    // Async reset between edges with a held word and a partial word in flight
    dout_ready = 1'b0;
    step1(1'b0); step1(1'b1); step1(1'b0); step1(1'b1);
    step1(1'b1); step1(1'b0); step1(1'b1); step1(1'b0);
    check("pre_reset_dout", dout, 32'h0000005A);
    step1(1'b1); step1(1'b1); step1(1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dout", dout, 32'h0);
    check("arst_valid", {31'b0, dout_valid}, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_ovf", {31'b0, ovf}, 32'h0);
    idle(1);
    rst = 1'b0;
    dout_ready = 1'b1;
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
